mem_port_arbiter: RTL

Shares the single-ported unified memory between the pipeline's instruction-fetch requester and data-memory requester (loads and stores). It serialises their requests onto one memory port with one transaction outstanding. A starvation guard keeps a long run of data accesses from locking out fetch. A branch/jump flush can cancel an outstanding fetch response. It sits between the fetch/memory units of the 5-stage core and the memory.

---
 rtl/mem_port_arbiter_pkg.sv | 30 +++
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter_rr_starve_guard.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the unified-memory port arbiter: FSM state
//   encoding, transaction owner encoding, reset/NOP constants and the
//   saturating streak-counter helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int unsigned STREAK_W   = 4;
  localparam logic        NOP_WRITE  = 1'b0;
  localparam logic [31:0] STAT_RESET = '0;

  // Increment, but never beyond the configured limit.
  function automatic logic [STREAK_W-1:0] streak_sat_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] limit
  );
    return (cur >= limit) ? limit : cur + 1'b1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the fetch requester, data requester and memory port signals.
//   slave  : the arbiter's view (requests/memory responses in, grants,
//            responses and memory request out).
//   master : the environment's view (fetch unit, MEM stage and memory).
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20
);

  // Fetch requester
  logic                    if_req;
  logic [ADDRESS_BITS-1:0] if_addr;
  logic                    if_gnt;
  logic                    if_rvalid;
  logic [DATA_WIDTH-1:0]   if_rdata;
  logic                    if_flush;

  // Data requester
  logic                    d_req;
  logic                    d_write;
  logic [ADDRESS_BITS-1:0] d_addr;
  logic [DATA_WIDTH-1:0]   d_wdata;
  logic                    d_gnt;
  logic                    d_rvalid;
  logic [DATA_WIDTH-1:0]   d_rdata;

  // Memory port
  logic                    mem_req;
  logic                    mem_write;
  logic [ADDRESS_BITS-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ready;
  logic                    mem_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  d_req, d_write, d_addr, d_wdata,
    input  mem_ready, mem_valid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    output d_req, d_write, d_addr, d_wdata,
    output mem_ready, mem_valid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_starve_guard.sv
// rr_starve_guard
//   Priority decision between fetch and data requesters plus the streak
//   counter that stops a run of data accesses from starving fetch.
//   clock_i, reset_i : clock, synchronous active-high reset
//   if_req_i, d_req_i: requests present this cycle
//   grant_i          : a grant is being issued this cycle to winner_o
//   winner_o         : owner selected (valid when either request is high)
//   forced_o         : fetch wins only because the streak hit its limit
module rr_starve_guard
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STREAK_LIMIT = 4
) (
  input  logic   clock_i,
  input  logic   reset_i,
  input  logic   if_req_i,
  input  logic   d_req_i,
  input  logic   grant_i,
  output owner_e winner_o,
  output logic   forced_o
);

  localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STREAK_LIMIT);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                at_limit;

  assign at_limit = (streak_q == LIMIT);

  always_comb begin
    forced_o = if_req_i && d_req_i && at_limit;
    winner_o = (d_req_i && !(if_req_i && at_limit)) ? OWN_D : OWN_IF;
  end

  // Streak only grows while fetch is actually waiting behind data.
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      if (winner_o == OWN_IF) begin
        streak_d = '0;
      end else if (if_req_i) begin
        streak_d = streak_sat_inc(streak_q, LIMIT);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises instruction-fetch and data-memory requests onto the single
//   unified memory port, one transaction outstanding at a time.
//   clock  : sole clock
//   reset  : synchronous, active-high
//   bus    : requester handshakes and memory port (slave modport)
//   busy   : FSM is not idle
//   report : print grant statistics tagged with CORE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter int unsigned STREAK_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic               busy,
  input  logic               report
);

  arb_state_e              state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic                    write_q, write_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    drop_q, drop_d;
  logic                    if_rvalid_q, if_rvalid_d;
  logic                    d_rvalid_q, d_rvalid_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic [31:0]             stat_if_q, stat_d_q, stat_forced_q;

  owner_e                  winner;
  logic                    forced;
  logic                    grant;
  logic                    if_gnt_c, d_gnt_c;

  // Grants are combinational from IDLE, so reset must mask them directly.
  assign grant    = (state_q == ST_IDLE) && (bus.if_req || bus.d_req) && !reset;
  assign if_gnt_c = grant && (winner == OWN_IF);
  assign d_gnt_c  = grant && (winner == OWN_D);

  rr_starve_guard #(
    .STREAK_LIMIT (STREAK_LIMIT)
  ) u_guard (
    .clock_i  (clock),
    .reset_i  (reset),
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .grant_i  (grant),
    .winner_o (winner),
    .forced_o (forced)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    drop_d      = drop_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = winner;
          drop_d  = 1'b0;
          state_d = ST_ISSUE;
          if (winner == OWN_D) begin
            write_d = bus.d_write;
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
          end else begin
            write_d = NOP_WRITE;
            addr_d  = bus.if_addr;
            wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if ((owner_q == OWN_IF) && bus.if_flush) drop_d = 1'b1;
        if (bus.mem_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_valid) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = write_q ? '0 : bus.mem_rdata;
          end else if (!drop_q && !bus.if_flush) begin
            // A flush coinciding with completion drops the response too.
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else if ((owner_q == OWN_IF) && bus.if_flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_IF;
      write_q       <= NOP_WRITE;
      addr_q        <= '0;
      wdata_q       <= '0;
      drop_q        <= 1'b0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      stat_if_q     <= STAT_RESET;
      stat_d_q      <= STAT_RESET;
      stat_forced_q <= STAT_RESET;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      drop_q      <= drop_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if (if_gnt_c)           stat_if_q     <= stat_if_q + 32'd1;
      if (d_gnt_c)            stat_d_q      <= stat_d_q + 32'd1;
      if (if_gnt_c && forced) stat_forced_q <= stat_forced_q + 32'd1;
    end
  end

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = (state_q == ST_ISSUE);
  assign bus.mem_write = write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q != ST_IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report) begin
      $display("mem_port_arbiter core %0d: fetch grants %0d, data grants %0d, forced fetches %0d",
               CORE, stat_if_q, stat_d_q, stat_forced_q);
    end
  end
`endif

endmodule
